// File: rtl/i2c_master_ctrl_if.sv
// Request/response and I2C bus signals of the i2c_master_ctrl block.
// "master" is the requesting side (it also drives back the sampled SDA line); "slave" is the controller.
interface i2c_master_ctrl_if;
    logic       ce;
    logic       wren;
    logic       rden;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       scl;
    logic       sda_oe;
    logic       sda_i;
    logic [3:0] state;

    modport master (
        output ce, wren, rden, addr, wdata, sda_i,
        input  rdata, busy, done, nack_err, scl, sda_oe, state
    );

    modport slave (
        input  ce, wren, rden, addr, wdata, sda_i,
        output rdata, busy, done, nack_err, scl, sda_oe, state
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, device byte, memory address, data byte, ACK bits, STOP.
// SCL/SDA are registered from the next-cycle slot position so the bus pins never glitch.
module i2c_master_ctrl #(
    parameter int QTR = 2
) (
    input  logic             clk,
    input  logic             reset,
    i2c_master_ctrl_if.slave bus
);
    localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        DEVADDR = 4'd2,
        ACK1    = 4'd3,
        MEMADDR = 4'd4,
        ACK2    = 4'd5,
        WDATA   = 4'd6,
        ACK3    = 4'd7,
        RDATA   = 4'd8,
        MACK    = 4'd9,
        STOP    = 4'd10
    } state_t;

    state_t        state, nxt_state;
    logic [QW-1:0] qcnt, nxt_qcnt;
    logic [1:0]    q, nxt_q;
    logic [2:0]    bitcnt, nxt_bit;
    logic [7:0]    addr_l, wdata_l, shreg, rdata_r, tx_byte;
    logic          rw, samp, nack_flag;
    logic          scl_r, sda_r, busy_r, done_r, nack_r;
    logic          nxt_scl, nxt_sda;
    logic          qwrap, slot_end, accept;

    always_comb begin
        qwrap     = (qcnt == QW'(QTR - 1));
        slot_end  = qwrap && (q == 2'd3);
        accept    = (state == IDLE) && bus.ce && (bus.wren || bus.rden);
        nxt_state = state;
        nxt_q     = qwrap ? q + 2'd1 : q;
        nxt_qcnt  = qwrap ? '0 : qcnt + QW'(1);
        nxt_bit   = bitcnt;

        if (state == IDLE) begin
            nxt_q    = 2'd0;
            nxt_qcnt = '0;
            nxt_bit  = 3'd0;
            if (accept)
                nxt_state = START;
        end else if (slot_end) begin
            case (state)
                START:   begin nxt_state = DEVADDR; nxt_bit = 3'd0; end
                DEVADDR: begin
                    if (bitcnt == 3'd7) nxt_state = ACK1;
                    nxt_bit = bitcnt + 3'd1;
                end
                ACK1:    nxt_state = samp ? STOP : MEMADDR;
                MEMADDR: begin
                    if (bitcnt == 3'd7) nxt_state = ACK2;
                    nxt_bit = bitcnt + 3'd1;
                end
                ACK2:    nxt_state = samp ? STOP : (rw ? RDATA : WDATA);
                WDATA:   begin
                    if (bitcnt == 3'd7) nxt_state = ACK3;
                    nxt_bit = bitcnt + 3'd1;
                end
                ACK3:    nxt_state = STOP;
                RDATA:   begin
                    if (bitcnt == 3'd7) nxt_state = MACK;
                    nxt_bit = bitcnt + 3'd1;
                end
                MACK:    nxt_state = STOP;
                STOP:    nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end

        case (nxt_state)
            DEVADDR: tx_byte = {5'b00000, addr_l[7:6], rw};
            MEMADDR: tx_byte = {2'b00, addr_l[5:0]};
            WDATA:   tx_byte = wdata_l;
            default: tx_byte = 8'h00;
        endcase

        // Data slots hold SCL low in q0/q3; ACK, read and MACK slots leave SDA to the slave.
        case (nxt_state)
            IDLE:    begin nxt_scl = 1'b1;             nxt_sda = 1'b0;             end
            START:   begin nxt_scl = (nxt_q != 2'd3);  nxt_sda = (nxt_q != 2'd0);  end
            STOP:    begin nxt_scl = (nxt_q != 2'd0);  nxt_sda = (nxt_q < 2'd2);   end
            DEVADDR, MEMADDR, WDATA: begin
                nxt_scl = (nxt_q == 2'd1) || (nxt_q == 2'd2);
                nxt_sda = ~tx_byte[3'd7 - nxt_bit];
            end
            default: begin
                nxt_scl = (nxt_q == 2'd1) || (nxt_q == 2'd2);
                nxt_sda = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            q         <= 2'd0;
            qcnt      <= '0;
            bitcnt    <= 3'd0;
            scl_r     <= 1'b1;
            sda_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            nack_r    <= 1'b0;
            rdata_r   <= 8'h00;
            addr_l    <= 8'h00;
            wdata_l   <= 8'h00;
            rw        <= 1'b0;
            samp      <= 1'b0;
            nack_flag <= 1'b0;
            shreg     <= 8'h00;
        end else begin
            state  <= nxt_state;
            q      <= nxt_q;
            qcnt   <= nxt_qcnt;
            bitcnt <= nxt_bit;
            scl_r  <= nxt_scl;
            sda_r  <= nxt_sda;
            done_r <= 1'b0;

            if (accept) begin
                addr_l    <= bus.addr;
                wdata_l   <= bus.wdata;
                rw        <= ~bus.wren;
                nack_flag <= 1'b0;
                busy_r    <= 1'b1;
            end

            // SDA is taken on the last clk of the first SCL-high quarter.
            if (state != IDLE && q == 2'd1 && qwrap) begin
                samp <= bus.sda_i;
                if (state == RDATA)
                    shreg <= {shreg[6:0], bus.sda_i};
            end

            if (slot_end && samp && (state == ACK1 || state == ACK2 || state == ACK3))
                nack_flag <= 1'b1;

            if (state == STOP && slot_end) begin
                done_r <= 1'b1;
                busy_r <= 1'b0;
                nack_r <= nack_flag;
                if (rw && !nack_flag)
                    rdata_r <= shreg;
            end
        end
    end

    assign bus.scl      = scl_r;
    assign bus.sda_oe   = sda_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.nack_err = nack_r;
    assign bus.rdata    = rdata_r;
    assign bus.state    = state;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C slave on the bus plus a transaction-level expectation model.
module tb_i2c_master_ctrl;
    localparam int QTR = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    i2c_master_ctrl_if bif();

    i2c_master_ctrl #(.QTR(QTR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model state
    logic       s_drive = 1'b0;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       in_txn = 1'b0;
    logic       dev_rw = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [2:0] ack_en = 3'b111;
    logic [7:0] rd_val = 8'h00;
    int         nbits = 0;
    int         starts = 0;
    int         stops = 0;
    int         done_cnt = 0;
    logic [8:0] seen[$];
    logic [7:0] m_rdata = 8'h00;

    assign bif.sda_i = ~(bif.sda_oe | s_drive);

    function automatic logic slave_drive(input int n);
        int b;
        int p;
        b = n / 9;
        p = n % 9;
        if (p == 8 && b <= 1) return ack_en[b];
        if (p == 8 && b == 2) return dev_rw ? 1'b0 : ack_en[2];
        if (b == 2 && p < 8 && dev_rw) return ~rd_val[7-p];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            s_drive <= 1'b0;
            in_txn  <= 1'b0;
            nbits   <= 0;
        end else if (p_scl && bif.scl && p_sda && !bif.sda_i) begin
            starts <= starts + 1;
            in_txn <= 1'b1;
            nbits  <= 0;
        end else if (p_scl && bif.scl && !p_sda && bif.sda_i) begin
            stops   <= stops + 1;
            in_txn  <= 1'b0;
            s_drive <= 1'b0;
        end else if (!p_scl && bif.scl && in_txn) begin
            cur <= {cur[6:0], bif.sda_i};
            if (nbits % 9 == 8) seen.push_back({cur, bif.sda_i});
            if (nbits == 7) dev_rw <= bif.sda_i;
            nbits <= nbits + 1;
        end else if (p_scl && !bif.scl && in_txn) begin
            s_drive <= slave_drive(nbits);
        end
        p_scl <= bif.scl;
        p_sda <= bif.sda_i;
        if (bif.done) done_cnt <= done_cnt + 1;
    end

    task automatic pulse_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic run_txn(input string nm, input logic wr, input logic rd, input logic [7:0] a,
                           input logic [7:0] wd, input logic [7:0] rv, input logic [2:0] acks,
                           input bit poke);
        logic       is_read;
        logic       exp_nack;
        logic [8:0] exp[$];
        int         slots;
        int         t0, d0, s0, e0;
        bit         got;
        is_read = !wr;
        exp.delete();
        exp.push_back({5'b00000, a[7:6], is_read, !acks[0]});
        if (!acks[0]) begin
            slots = 11; exp_nack = 1'b1;
        end else begin
            exp.push_back({2'b00, a[5:0], !acks[1]});
            if (!acks[1]) begin
                slots = 20; exp_nack = 1'b1;
            end else begin
                slots = 29;
                if (is_read) begin exp.push_back({rv, 1'b1}); exp_nack = 1'b0; end
                else begin exp.push_back({wd, !acks[2]}); exp_nack = !acks[2]; end
            end
        end
        if (is_read && !exp_nack) m_rdata = rv;

        ack_en = acks; rd_val = rv; seen.delete();
        d0 = done_cnt; s0 = starts; e0 = stops;
        @(negedge clk);
        bif.ce = 1'b1; bif.wren = wr; bif.rden = rd; bif.addr = a; bif.wdata = wd;
        @(negedge clk);
        bif.ce = 1'b0; bif.wren = 1'b0; bif.rden = 1'b0;
        tests++;
        if (bif.busy !== 1'b1) begin fails++; $display("FAIL %s busy_rise: got %b want 1", nm, bif.busy); end
        t0 = cyc; got = 0;
        for (int i = 0; i < 200*QTR && !got; i++) begin
            @(negedge clk);
            if (poke && i == 10) begin bif.ce = 1'b1; bif.rden = 1'b1; bif.wren = 1'b1; bif.addr = ~a; end
            else if (poke && i == 11) begin bif.ce = 1'b0; bif.rden = 1'b0; bif.wren = 1'b0; end
            if (bif.done === 1'b1) got = 1;
        end
        tests++;
        if (!got) begin
            fails++; $display("FAIL %s done_timeout: no done within %0d cycles", nm, 200*QTR);
            pulse_reset(2);
            return;
        end
        tests++;
        if (cyc - t0 != slots*4*QTR) begin fails++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - t0, slots*4*QTR); end
        tests++;
        if (bif.nack_err !== exp_nack) begin fails++; $display("FAIL %s nack_err: got %b want %b", nm, bif.nack_err, exp_nack); end
        tests++;
        if (bif.rdata !== m_rdata) begin fails++; $display("FAIL %s rdata: got %h want %h", nm, bif.rdata, m_rdata); end
        tests++;
        if (bif.busy !== 1'b0) begin fails++; $display("FAIL %s busy_at_done: got %b want 0", nm, bif.busy); end
        @(negedge clk);
        tests++;
        if (bif.done !== 1'b0) begin fails++; $display("FAIL %s done_width: got %b want 0", nm, bif.done); end
        repeat (4*QTR + 2) @(negedge clk);
        tests++;
        if (done_cnt != d0 + 1) begin fails++; $display("FAIL %s done_count: got %0d want %0d", nm, done_cnt - d0, 1); end
        tests++;
        if (starts != s0 + 1 || stops != e0 + 1) begin
            fails++; $display("FAIL %s start_stop: got %0d/%0d want 1/1", nm, starts - s0, stops - e0);
        end
        tests++;
        if (seen.size() != exp.size()) begin
            fails++; $display("FAIL %s byte_count: got %0d want %0d", nm, seen.size(), exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                tests++;
                if (seen[k] !== exp[k]) begin
                    fails++; $display("FAIL %s byte%0d {data,ack}: got %h want %h", nm, k, seen[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        bif.ce = 1'b0; bif.wren = 1'b0; bif.rden = 1'b0; bif.addr = 8'h00; bif.wdata = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bif.scl !== 1'b1) begin fails++; $display("FAIL reset scl: got %b want 1", bif.scl); end
        tests++; if (bif.sda_oe !== 1'b0) begin fails++; $display("FAIL reset sda_oe: got %b want 0", bif.sda_oe); end
        tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", bif.busy); end
        tests++; if (bif.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", bif.done); end
        tests++; if (bif.nack_err !== 1'b0) begin fails++; $display("FAIL reset nack_err: got %b want 0", bif.nack_err); end
        tests++; if (bif.rdata !== 8'h00) begin fails++; $display("FAIL reset rdata: got %h want 00", bif.rdata); end
        tests++; if (bif.state !== 4'd0) begin fails++; $display("FAIL reset state: got %0d want 0", bif.state); end
        reset = 1'b0;
        m_rdata = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();      run_txn("read",  1'b0, 1'b1, 8'h41, 8'h00, 8'hA5, 3'b111, 1'b0); endtask
    task automatic test_write();     run_txn("write", 1'b1, 1'b0, 8'h42, 8'h7F, 8'h00, 3'b111, 1'b0); endtask
    task automatic test_nack();      run_txn("nack",  1'b0, 1'b1, 8'hC1, 8'h00, 8'h3C, 3'b000, 1'b0); endtask
    task automatic test_busy();      run_txn("busy",  1'b0, 1'b1, 8'h85, 8'h00, 8'h5A, 3'b111, 1'b1); endtask
    task automatic test_both();      run_txn("both",  1'b1, 1'b1, 8'h7E, 8'hC3, 8'h00, 3'b111, 1'b0); endtask

    task automatic test_ce0();
        int s0, bad;
        s0 = starts; bad = 0;
        @(negedge clk);
        bif.ce = 1'b0; bif.rden = 1'b1; bif.wren = 1'b1; bif.addr = 8'h55;
        repeat (8*QTR) begin
            @(negedge clk);
            if (bif.busy !== 1'b0 || bif.state !== 4'd0 || bif.scl !== 1'b1 || bif.sda_oe !== 1'b0) bad++;
        end
        bif.rden = 1'b0; bif.wren = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL ce0 idle_bus: got %0d bad cycles want 0", bad); end
        tests++; if (starts != s0) begin fails++; $display("FAIL ce0 start: got %0d want 0", starts - s0); end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit hit;
        ack_en = 3'b111; rd_val = 8'h99; hit = 0;
        @(negedge clk);
        bif.ce = 1'b1; bif.rden = 1'b1; bif.addr = 8'h4A;
        @(negedge clk);
        bif.ce = 1'b0; bif.rden = 1'b0;
        for (int i = 0; i < 100*QTR && !hit; i++) begin
            @(negedge clk);
            if (bif.state === 4'd4) hit = 1;
        end
        tests++; if (!hit) begin fails++; $display("FAIL rstmid reach_memaddr: state %0d want 4", bif.state); end
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        tests++; if (bif.scl !== 1'b1) begin fails++; $display("FAIL rstmid scl: got %b want 1", bif.scl); end
        tests++; if (bif.sda_oe !== 1'b0) begin fails++; $display("FAIL rstmid sda_oe: got %b want 0", bif.sda_oe); end
        tests++; if (bif.busy !== 1'b0) begin fails++; $display("FAIL rstmid busy: got %b want 0", bif.busy); end
        @(negedge clk);
        reset = 1'b0;
        m_rdata = 8'h00;
        repeat (150*QTR) @(negedge clk);
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL rstmid no_done: got %0d pulses want 0", done_cnt - d0); end
        tests++; if (bif.rdata !== 8'h00) begin fails++; $display("FAIL rstmid rdata: got %h want 00", bif.rdata); end
    endtask

    task automatic test_random();
        logic [2:0] acks;
        int op, r;
        for (int n = 0; n < 16; n++) begin
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 7);
            acks = (r < 5) ? 3'b111 : (r == 5) ? 3'b110 : (r == 6) ? 3'b101 : 3'b011;
            run_txn("rand", op != 0, op != 1, 8'($urandom), 8'($urandom), 8'($urandom), acks, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_nack();
        test_busy();
        test_both();
        test_ce0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- APB-side controller that turns single-byte memory read/write requests into complete I2C master transactions toward I2C_Slave devices.
- Sequences every transaction as START, device byte, memory-address byte, data byte, acknowledge bits and STOP.
- Generates SCL from the system clock and drives SDA open-drain. Reports read data, completion and slave NACK back to the APB side.

Parameters:
QTR, 2, clk cycles per SCL quarter-period (>=1); one bit slot = 4*QTR clk cycles.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
ce  input  1  chip enable; a request is valid only when ce=1.
wren  input  1  write request.
rden  input  1  read request.
addr  input  8  [7:6] device id, [5:0] slave memory address.
wdata  input  8  write data.
rdata  output  8  read data; valid when done=1 after a read.
busy  output  1  transaction in progress.
done  output  1  one-cycle completion pulse.
nack_err  output  1  slave NACKed; valid with done.
scl  output  1  I2C clock.
sda_oe  output  1  1 = pull SDA low; 0 = release (bus pulled high).
sda_i  input  1  sampled SDA line.
state  output  4  current FSM state, for debug.

Behaviour:
- Reset values: scl=1, sda_oe=0, busy=0, done=0, nack_err=0, rdata=0, state=IDLE. Quarter and bit counters cleared.
- Reset mid-transaction: bus is released immediately with no STOP and no done pulse.
- Accept rule: request accepted on a posedge with state=IDLE, ce=1 and (wren|rden).
  - wren wins if both are asserted.
  - addr, wdata and the direction are latched at acceptance.
  - busy=1 from the next cycle. Requests while busy=1 are ignored.
- Quarter counter: counts 0..QTR-1 and advances quarter q0..q3 on wrap. State changes only at the end of q3.
- Bit slot (SCL low = q0,q3; SCL high = q1,q2):
  - sda_oe is updated at the start of q0 and held through q3.
  - sda_i is sampled on the last clk of q1.
- START slot:
  - q0: scl=1, sda released.
  - q1–q2: scl=1, sda low.
  - q3: scl=0, sda low.
- STOP slot:
  - q0: scl=0, sda low.
  - q1: scl=1, sda low.
  - q2–q3: scl=1, sda released.
- FSM states (encoding in parentheses):
  - IDLE(0), START(1), DEVADDR(2), ACK1(3), MEMADDR(4), ACK2(5), WDATA(6), ACK3(7), RDATA(8), MACK(9), STOP(10).
- Transitions and data, all bytes sent MSB first:
  - IDLE -> START on accept.
  - DEVADDR: 8 slots, byte = {5'b00000, id[1:0], rw}, rw=1 for read.
  - ACK1: slave drives. sda_i=0 -> MEMADDR; sda_i=1 -> STOP with nack flag.
  - MEMADDR: 8 slots, byte = {2'b00, addr[5:0]}.
  - ACK2: sda_i=0 -> WDATA for a write, RDATA for a read; sda_i=1 -> STOP with nack flag.
  - WDATA: 8 slots, byte = wdata. ACK3: sda_i=1 sets nack flag. Always -> STOP.
  - RDATA: SDA released; 8 sampled bits shift into a register.
  - MACK: master releases SDA (NACK, single byte) -> STOP.
  - STOP -> IDLE.
- Completion, on the cycle state returns to IDLE:
  - done=1 for exactly one cycle; busy=0 in the same cycle.
  - nack_err = nack flag; rdata updated for a successful read only; rdata holds otherwise.
- Latency without NACK: 29 slots (1+9+9+9+1) = 116*QTR cycles from busy rising to done.
- NACK at ACK1: 11 slots (44*QTR cycles). Remaining bytes are skipped; no data phase.
- Idle bus: scl=1, sda_oe=0 continuously.

Test Plan:
- Reset: hold reset 3 cycles mid-idle -> all outputs at reset values, state=0.
- Read: addr=8'h41, rden=1, ce=1, slave ACKs and returns 8'hA5.
  - SDA bytes 8'h03 then 8'h01; master NACKs; STOP seen.
  - done at 116*QTR cycles; rdata=8'hA5; nack_err=0.
- Write: addr=8'h42, wdata=8'h7F, wren=1, slave ACKs all.
  - Bytes 8'h02, 8'h02, 8'h7F, then STOP.
  - done with nack_err=0; rdata unchanged (8'hA5).
- NACK: addr=8'hC1 read, slave leaves ACK1 high.
  - STOP follows the ACK1 slot; done after 44*QTR cycles; nack_err=1; rdata unchanged.
- Busy / collision:
  - Second rden pulse while busy -> ignored; exactly one transaction and one done.
  - wren=rden=1 -> write transaction (rw bit 0).
  - ce=0 -> request not accepted.
- Reset mid-operation: assert reset during MEMADDR -> next cycle scl=1, sda_oe=0, busy=0, and no done pulse.
